// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

  typedef enum logic {DRAIN_IDLE, DRAIN_ACTIVE} drain_state_e;

  localparam int SKID_DEPTH = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry in-order output buffer; head entry drives the output stream.
module fifo_out_buf
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_valid
);

  logic [DATA_WIDTH-1:0] slot0;
  logic [DATA_WIDTH-1:0] slot1;
  logic                  do_pop;
  logic                  do_push;

  always_comb begin
    do_pop  = pop & (occ != 2'd0);
    do_push = push & ((occ != 2'(SKID_DEPTH)) | do_pop);
  end

  // slot0 only changes on a pop or on a push into an empty buffer, so the
  // head word is held while it waits for the consumer.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      occ   <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) slot0 <= push_data;
          else             slot1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = slot0;
  assign head_valid = (occ != 2'd0);

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller: bursts FIFO reads on threshold, flush request or
// (with FIFO_DRAIN_TIMEOUT_EN defined) an idle timeout, into a valid/ready stream.
module fifo_drain_ctrl
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BURST_LEN      = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_in,
  input  logic                  areset_b,
  input  logic                  fifo_empty_ind,
  input  logic                  fifo_threshold_ind,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_trans_read,
  input  logic                  drain_req,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_drained,
  output drain_state_e          dbg_state
);

  if (BURST_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fifo_drain_ctrl: BURST_LEN and TIMEOUT_CYCLES must be at least 1");
  end

  localparam int BC_W = $clog2(BURST_LEN + 1);

  drain_state_e    state;
  drain_state_e    state_nxt;
  logic            flush_mode;
  logic            flush_nxt;
  logic [BC_W-1:0] burst_cnt;
  logic [BC_W:0]   burst_sum;
  logic            burst_hit;
  logic            exit_cond;
  logic            rd;
  logic            pop;
  logic            timeout_hit;
  logic [1:0]      occ;
  logic            head_valid;

  // Stream handshake: a word transfers on every edge where m_valid and
  // m_ready are both high; m_valid never depends on m_ready, and m_data is
  // held while m_valid is high and m_ready is low.
  assign pop = m_valid & m_ready;

  // occ==2 blocks the read even if a pop is pending, so m_ready has no
  // combinational path to the FIFO strobe.
  assign rd = (state == DRAIN_ACTIVE) & ~fifo_empty_ind & (occ != 2'(SKID_DEPTH));

  assign burst_sum = {1'b0, burst_cnt} + {{BC_W{1'b0}}, rd};
  assign burst_hit = (burst_sum >= (BC_W + 1)'(BURST_LEN));

  // A drain_req arriving in the last burst cycle keeps the burst going.
  assign exit_cond = (state == DRAIN_ACTIVE) &
                     (fifo_empty_ind | (burst_hit & ~flush_mode & ~drain_req));

`ifdef FIFO_DRAIN_TIMEOUT_EN
  localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      to_cnt <= '0;
    end else if ((state == DRAIN_ACTIVE) || fifo_empty_ind) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_LAST) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign timeout_hit = (state == DRAIN_IDLE) & ~fifo_empty_ind & (to_cnt == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    flush_nxt = flush_mode;
    unique case (state)
      DRAIN_IDLE: begin
        if (fifo_threshold_ind || drain_req || timeout_hit) state_nxt = DRAIN_ACTIVE;
      end
      DRAIN_ACTIVE: begin
        if (exit_cond) state_nxt = DRAIN_IDLE;
      end
      default: state_nxt = DRAIN_IDLE;
    endcase
    // Exiting on an empty FIFO already satisfies any flush, so exit wins.
    if (exit_cond)      flush_nxt = 1'b0;
    else if (drain_req) flush_nxt = 1'b1;
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      state      <= DRAIN_IDLE;
      flush_mode <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_mode <= flush_nxt;
    end
  end

  // Held at zero while idle, so every burst starts from zero; saturates
  // during long flushes.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      burst_cnt <= '0;
    end else if (state == DRAIN_IDLE) begin
      burst_cnt <= '0;
    end else if (rd && (burst_cnt != {BC_W{1'b1}})) begin
      burst_cnt <= burst_cnt + BC_W'(1);
    end
  end

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      words_drained <= '0;
    end else if (pop) begin
      words_drained <= words_drained + CNT_WIDTH'(1);
    end
  end

  fifo_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk_in     (clk_in),
    .areset_b   (areset_b),
    .push       (rd),
    .push_data  (fifo_data_out),
    .pop        (pop),
    .occ        (occ),
    .head_data  (m_data),
    .head_valid (head_valid)
  );

  assign m_valid         = head_valid;
  assign fifo_trans_read = rd;
  assign busy            = (state == DRAIN_ACTIVE) | (occ != 2'd0);
  assign dbg_state       = state;

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Self-checking bench for fifo_drain_ctrl with a behavioural FIFO and an
// in-order scoreboard of every word written into the FIFO.
module tb_fifo_drain_ctrl;
  import fifo_drain_pkg::*;

  localparam int DW = 32;
  localparam int BL = 2;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk_in;
  logic          areset_b;
  logic          fifo_empty_ind;
  logic          fifo_threshold_ind;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_trans_read;
  logic          drain_req;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [CW-1:0] words_drained;
  drain_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  fifo_drain_ctrl #(
    .DATA_WIDTH     (DW),
    .BURST_LEN      (BL),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk_in             (clk_in),
    .areset_b           (areset_b),
    .fifo_empty_ind     (fifo_empty_ind),
    .fifo_threshold_ind (fifo_threshold_ind),
    .fifo_data_out      (fifo_data_out),
    .fifo_trans_read    (fifo_trans_read),
    .drain_req          (drain_req),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_ready            (m_ready),
    .busy               (busy),
    .words_drained      (words_drained),
    .dbg_state          (dbg_state)
  );

  // ---------------- behavioural FIFO ----------------
  logic [DW-1:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_total = 0;
  bit underflow = 1'b0;
  logic thr_drv;

  assign fifo_empty_ind     = (wr_ptr == rd_ptr);
  assign fifo_data_out      = mem[rd_ptr[5:0]];
  assign fifo_threshold_ind = thr_drv;

  always @(posedge clk_in) begin
    if (fifo_trans_read) begin
      rd_total <= rd_total + 1;
      if (fifo_empty_ind) underflow <= 1'b1;
      else                rd_ptr    <= rd_ptr + 1;
    end
  end

  // ---------------- output monitor ----------------
  logic [DW-1:0] got_mem [0:1023];
  int got_wr = 0;
  int got_rd = 0;
  int stab_viol = 0;
  bit stall_prev = 1'b0;
  logic [DW-1:0] stall_data = '0;

  always @(negedge clk_in) begin
    if (!areset_b) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev && (!m_valid || (m_data != stall_data))) stab_viol <= stab_viol + 1;
      if (m_valid && m_ready) begin
        got_mem[got_wr[9:0]] <= m_data;
        got_wr <= got_wr + 1;
      end
      stall_prev <= m_valid && !m_ready;
      stall_data <= m_data;
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int wd_base = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_flush(input string name);
    while (got_rd < got_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: unexpected word %0h, expected none", name, got_mem[got_rd[9:0]]);
      end else begin
        check(name, got_mem[got_rd[9:0]], exp_q.pop_front());
      end
      got_rd++;
    end
  endtask

  task automatic check_wd(input string name);
    check(name, DW'(words_drained), DW'((got_wr - wd_base) % (1 << CW)));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic wait_quiet(input bit need_empty, input int budget, input string name);
    int n = 0;
    while ((busy || (need_empty && !fifo_empty_ind)) && (n < budget)) begin
      tick(1);
      n++;
    end
    if (busy || (need_empty && !fifo_empty_ind)) begin
      checks++;
      errors++;
      $display("FAIL %s: not quiet after %0d cycles, busy=%0b empty=%0b", name, n, busy, fifo_empty_ind);
    end
  endtask

  task automatic flush(input string name);
    drain_req = 1'b1;
    tick(1);
    drain_req = 1'b0;
    wait_quiet(1'b1, 300, name);
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int n_words;
    bit use_drain;
    int exp_reads;
    int exp_left;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int rd0;
    int first_rd;

    vecs[0] = '{1, 1'b0, 1, 0};
    vecs[1] = '{2, 1'b0, 2, 0};
    vecs[2] = '{5, 1'b0, 2, 3};
    vecs[3] = '{3, 1'b1, 3, 0};
    vecs[4] = '{6, 1'b1, 6, 0};
    vecs[5] = '{1, 1'b1, 1, 0};

    areset_b  = 1'b0;
    thr_drv   = 1'b0;
    drain_req = 1'b0;
    m_ready   = 1'b0;

    // Reset with a loaded FIFO
    push_word(32'hA000_0001);
    push_word(32'hA000_0002);
    push_word(32'hA000_0003);
    tick(3);
    check("rst_m_valid", DW'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_trans_read", DW'(fifo_trans_read), 0);
    check("rst_busy", DW'(busy), 0);
    check("rst_words_drained", DW'(words_drained), 0);
    check("rst_state", DW'(dbg_state), DW'(DRAIN_IDLE));
    areset_b = 1'b1;
    tick(1);
    wd_base = got_wr;

    // Threshold burst: exactly BURST_LEN reads, in order
    rd0 = rd_total;
    m_ready = 1'b1;
    thr_drv = 1'b1;
    tick(1);
    thr_drv = 1'b0;
    check("thr_state", DW'(dbg_state), DW'(DRAIN_ACTIVE));
    check("thr_rd0", DW'(fifo_trans_read), 1);
    check("thr_valid0", DW'(m_valid), 0);
    tick(1);
    check("thr_rd1", DW'(fifo_trans_read), 1);
    check("thr_valid1", DW'(m_valid), 1);
    check("thr_data1", m_data, 32'hA000_0001);
    tick(1);
    check("thr_rd2", DW'(fifo_trans_read), 0);
    check("thr_data2", m_data, 32'hA000_0002);
    check("thr_exit", DW'(dbg_state), DW'(DRAIN_IDLE));
    tick(1);
    check("thr_valid3", DW'(m_valid), 0);
    check("thr_busy3", DW'(busy), 0);
    check("thr_reads", DW'(rd_total - rd0), 2);
    check_wd("thr_wd");
    sb_flush("thr_data");

    // Flush: four consecutive reads, ignores BURST_LEN
    push_word(32'hB000_0001);
    push_word(32'hB000_0002);
    push_word(32'hB000_0003);
    rd0 = rd_total;
    drain_req = 1'b1;
    tick(1);
    drain_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("flush_rd", DW'(fifo_trans_read), 1);
      tick(1);
    end
    check("flush_rd_end", DW'(fifo_trans_read), 0);
    check("flush_busy_last", DW'(busy), 1);
    tick(1);
    check("flush_busy_off", DW'(busy), 0);
    check("flush_reads", DW'(rd_total - rd0), 4);
    check_wd("flush_wd");
    sb_flush("flush_data");

    // Back-pressure: two reads then strobe held low, head word stable
    m_ready = 1'b0;
    push_word(32'hC000_0001);
    push_word(32'hC000_0002);
    push_word(32'hC000_0003);
    rd0 = rd_total;
    thr_drv = 1'b1;
    tick(1);
    thr_drv = 1'b0;
    check("bp_rd0", DW'(fifo_trans_read), 1);
    tick(1);
    check("bp_rd1", DW'(fifo_trans_read), 1);
    check("bp_data1", m_data, 32'hC000_0001);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("bp_rd_hold", DW'(fifo_trans_read), 0);
      check("bp_data_hold", m_data, 32'hC000_0001);
      tick(1);
    end
    m_ready = 1'b1;
    tick(3);
    check("bp_busy", DW'(busy), 0);
    check("bp_reads", DW'(rd_total - rd0), 2);
    check_wd("bp_wd");
    sb_flush("bp_data");
    flush("bp_residue");
    sb_flush("bp_residue_data");

    // drain_req on an empty FIFO
    rd0 = rd_total;
    drain_req = 1'b1;
    tick(1);
    drain_req = 1'b0;
    check("empty_state", DW'(dbg_state), DW'(DRAIN_ACTIVE));
    check("empty_rd", DW'(fifo_trans_read), 0);
    tick(1);
    check("empty_back_idle", DW'(dbg_state), DW'(DRAIN_IDLE));
    check("empty_busy", DW'(busy), 0);
    check("empty_reads", DW'(rd_total - rd0), 0);
    check("empty_underflow", DW'(underflow), 0);

    // Single residual word with no threshold
    rd0 = rd_total;
    push_word(32'hD000_0001);
`ifdef FIFO_DRAIN_TIMEOUT_EN
    first_rd = -1;
    for (int i = 0; i <= 20; i++) begin
      if (fifo_trans_read && (first_rd < 0)) first_rd = i;
      tick(1);
    end
    check("timeout_first_read", DW'(first_rd), DW'(TO));
    wait_quiet(1'b1, 50, "timeout_drain");
`else
    first_rd = 0;
    for (int i = 0; i < 100; i++) tick(1);
    check("no_timeout_reads", DW'(rd_total - rd0), DW'(first_rd));
    flush("no_timeout_flush");
`endif
    sb_flush("timeout_data");
    check_wd("timeout_wd");

    // Table-driven bursts
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < vecs[v].n_words; k++) push_word(DW'(32'hE000_0000 + v * 256 + k));
      rd0 = rd_total;
      if (vecs[v].use_drain) drain_req = 1'b1;
      else                   thr_drv   = 1'b1;
      tick(1);
      drain_req = 1'b0;
      thr_drv   = 1'b0;
      tick(vecs[v].n_words + 6);
      check("vec_reads", DW'(rd_total - rd0), DW'(vecs[v].exp_reads));
      check("vec_left", DW'(wr_ptr - rd_ptr), DW'(vecs[v].exp_left));
      check("vec_busy", DW'(busy), 0);
      flush("vec_flush");
      sb_flush("vec_data");
      check_wd("vec_wd");
    end

    // Asynchronous reset mid-burst with a full buffer
    m_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push_word(DW'(32'hF000_0000 + k));
    drain_req = 1'b1;
    tick(1);
    drain_req = 1'b0;
    tick(2);
    check("mid_valid_before", DW'(m_valid), 1);
    check("mid_state_before", DW'(dbg_state), DW'(DRAIN_ACTIVE));
    areset_b = 1'b0;
    #2;
    check("mid_rst_valid", DW'(m_valid), 0);
    check("mid_rst_busy", DW'(busy), 0);
    check("mid_rst_state", DW'(dbg_state), DW'(DRAIN_IDLE));
    check("mid_rst_rd", DW'(fifo_trans_read), 0);
    check("mid_rst_wd", DW'(words_drained), 0);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick(1);
    areset_b = 1'b1;
    wd_base = got_wr;
    tick(1);
    m_ready = 1'b1;
    flush("mid_rst_flush");
    sb_flush("mid_rst_data");
    check_wd("mid_rst_wd_after");

    // Counter wrap: 17 pops on a 4-bit counter
    areset_b = 1'b0;
    tick(1);
    areset_b = 1'b1;
    wd_base = got_wr;
    tick(1);
    for (int k = 0; k < 17; k++) push_word(DW'(32'h5000_0000 + k));
    flush("wrap_flush");
    sb_flush("wrap_data");
    check("wrap_wd", DW'(words_drained), 1);

    // Randomized traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      if (($urandom_range(0, 3) == 0) && ((wr_ptr - rd_ptr) < 40)) push_word($urandom);
      thr_drv   = ($urandom_range(0, 7) == 0);
      drain_req = ($urandom_range(0, 19) == 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      tick(1);
      if ((c % 50) == 49) sb_flush("rand_data");
    end
    thr_drv   = 1'b0;
    drain_req = 1'b0;
    m_ready   = 1'b1;
    tick(2);
    flush("rand_end_flush");
    sb_flush("rand_end_data");
    check("rand_exp_left", DW'(exp_q.size()), 0);
    check_wd("rand_wd");
    check("underflow", DW'(underflow), 0);
    check("m_data_stability", DW'(stab_viol), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
